// File: rtl/dec_keypad_encoder_pkg.sv
// Shared types and defaults for the debounced keypad encoder.
package dec_enc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESENT  = 2'd2,
      HELD     = 2'd3
   } kp_state_e;

   localparam int DEF_N_KEYS          = 10;
   localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/dec_keypad_encoder_onehot_index.sv
// Combinational one-hot decoder: bit position of a single set bit plus
// zero / one-hot classification of the vector.
module onehot_index #(
   parameter  int N = 2,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] index,
   output logic         is_zero,
   output logic         is_onehot
);

   always_comb begin
      index = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) index = index | W'(i);
      end
   end

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   assign is_zero   = (vec == '0);
   assign is_onehot = !is_zero && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/dec_keypad_encoder.sv
// Debounced keypad encoder: synchronises one-hot key lines and emits one
// binary code per stable keystroke on a valid/ready port.
module dec_keypad_encoder
   import dec_enc_pkg::*;
#(
   parameter  int N_KEYS          = DEF_N_KEYS,
   parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   localparam int W               = $clog2(N_KEYS),
   localparam int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [W-1:0]      code_out,
   output logic              code_valid,
   input  logic              code_ready,
   output logic              multi_err
);

   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] sync1_q, key_s_q;
   logic [N_KEYS-1:0] pat_q, pat_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [W-1:0]      code_q, code_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   kp_state_e         state_q, state_d;

   logic [W-1:0]      key_idx;
   logic              key_zero, key_onehot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         key_s_q <= '0;
      end else begin
         sync1_q <= key_in;
         key_s_q <= sync1_q;
      end
   end

   onehot_index #(.N(N_KEYS)) u_dec (
      .vec       (key_s_q),
      .index     (key_idx),
      .is_zero   (key_zero),
      .is_onehot (key_onehot)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (key_onehot) begin
               state_d = DEBOUNCE;
               pat_d   = key_s_q;
               cnt_d   = CW'(1);
            end else if (!key_zero) begin
               state_d = HELD;
               err_d   = 1'b1;
            end
         end
         DEBOUNCE: begin
            if (key_s_q == pat_q) begin
               if (cnt_q == CNT_LAST) begin
                  // key_s equals the latched pattern here, so its index is the code
                  state_d = PRESENT;
                  code_d  = key_idx;
                  valid_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         PRESENT: begin
            if (valid_q && code_ready) begin
               state_d = HELD;
               valid_d = 1'b0;
            end
         end
         HELD: begin
            if (key_zero) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign code_out   = code_q;
   assign code_valid = valid_q;
   assign multi_err  = err_q;

endmodule

// File: doc/dec_keypad_encoder.md
# dec_keypad_encoder

Debounced, handshaked decimal-keypad-to-binary encoder, parametrised in key count and debounce length. It takes N one-hot key lines, synchronises them, and waits until a single key has been stable for a programmable number of cycles. It then presents the key's binary index on a valid/ready interface, once per press. It sits between raw keypad/switch inputs and any downstream consumer (display driver, command FSM) that needs one clean code per keystroke plus an error indication for multi-key presses.

## Interface
- N_KEYS, 10, number of key lines; legal range 2..64
- DEBOUNCE_CYCLES, 4, consecutive stable samples required before a press is accepted; legal minimum 2
- W (localparam), $clog2(N_KEYS), width of code_out
- CW (localparam), $clog2(DEBOUNCE_CYCLES+1), width of the debounce counter

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- key_in  in  N_KEYS  raw key lines; key_in[i] high means digit i is pressed; may be asynchronous to clk
- code_out  out  W  binary index of the accepted key
- code_valid  out  1  code_out holds an unconsumed code
- code_ready  in  1  consumer accepts code_out when high together with code_valid
- multi_err  out  1  one-cycle pulse: more than one key seen pressed in IDLE

## Operation
- Input path: 2-flop synchroniser on every key_in bit; key_s is the second-stage output. The FSM sees only key_s.
- Decode of key_s: zero, one-hot (index = position of the set bit), or multi-hot.
- FSM states:
  - IDLE:
    - key_s zero: stay.
    - key_s one-hot: go to DEBOUNCE, latch the pattern, set cnt=1.
    - key_s multi-hot: go to HELD and pulse multi_err.
  - DEBOUNCE:
    - key_s equals the latched pattern and cnt<DEBOUNCE_CYCLES-1: cnt++.
    - key_s equals the latched pattern and cnt==DEBOUNCE_CYCLES-1: go to PRESENT, load code_out with the index, set code_valid=1.
    - key_s differs from the latched pattern (including zero or multi-hot): go to IDLE, cnt=0.
  - PRESENT: code_valid held high and code_out stable until code_valid&&code_ready. On that edge go to HELD and clear code_valid. Key release or change does not withdraw the code.
  - HELD: wait for key_s==0, then go to IDLE. One code per press, with no auto-repeat.
- code_ready while code_valid is low is ignored.
- code_out keeps its last value after handshake; only code_valid qualifies it.
- multi_err is registered; it is high for exactly the one cycle after the IDLE→HELD multi-hot transition.
- A multi-hot pattern arising in DEBOUNCE returns the FSM to IDLE. multi_err then pulses on the following edge if the pattern persists.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, cnt=0, synchroniser flops=0
  - code_out=0, code_valid=0, multi_err=0
- Press latency: let E0 be the first edge that samples a stable one-hot key_in.
  - key_s is valid after E1.
  - DEBOUNCE is entered at E2.
  - code_valid rises after edge E(DEBOUNCE_CYCLES+1); with the default of 4, that is after E5.
- Handshake: code_valid falls on the edge after the sampled code_valid&&code_ready. With code_ready tied high, code_valid is high for exactly 1 cycle.
- Backpressure: with code_ready low, code_valid stays high indefinitely and code_out does not change.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES samples in key_s never produces code_valid.
- Minimum spacing between presses: key_s must be zero for at least one edge in HELD, then the full debounce restarts.
- Reset mid-operation: any state aborts. A key held across reset deassertion is treated as a fresh press and re-debounced from the synchroniser.
- Highest key: key_in[N_KEYS-1] alone gives code_out=N_KEYS-1, e.g. 9 = 4'b1001 at the default.

## Structure
- Package dec_enc_pkg:
  - state typedef (IDLE, DEBOUNCE, PRESENT, HELD)
  - default N_KEYS/DEBOUNCE_CYCLES constants
- Sub-module onehot_index (parameter N):
  - purely combinational
  - outputs index[$clog2(N)-1:0], is_zero, is_onehot
  - reused for any future one-hot encoders
- Top level contains the synchroniser, FSM, counter and output registers.

## Test plan
- Reset, then hold key_in=10'b0000001000 (digit 3) stable with code_ready=1 → code_valid high for 1 cycle after E5, code_out=4'd3, multi_err=0. No second code while the key stays held.
- Press digit 9 with code_ready=0 for 20 cycles, then raise code_ready → code_valid held 20+ cycles with code_out=4'd9 constant, falling one edge after ready. Releasing the key mid-wait does not drop valid.
- key_in digit 5 for 3 cycles, then 0 (DEBOUNCE_CYCLES=4) → no code_valid. A subsequent 10-cycle press of digit 5 → code_out=4'd5.
- key_in=10'b0000100100 (digits 2 and 5) from IDLE → multi_err high exactly one cycle and no code_valid. After release and a press of digit 0 → code_out=4'd0.
- Assert rst while in PRESENT with digit 7 held → code_valid and code_out drop to 0 immediately. After deassertion with the key still held → code 7 is re-presented after the full debounce latency.
- Parameter sweep N_KEYS=16, DEBOUNCE_CYCLES=2: press key 15 → code_out=4'hF after edge E3.
